// File: rtl/seq_detector_param.sv
// Parameterised serial pattern detector: KMP prefix tracking, Mealy match output,
// optional saturating match counter enabled by the SEQ_DET_CNT_EN macro.
module seq_detector_param #(
  parameter int               PAT_W   = 4,
  parameter logic [PAT_W-1:0] PATTERN = 4'b1010,
  parameter int               CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             x,
  input  logic             in_valid,
  input  logic             overlap,
  input  logic             clr,
  output logic             z,
  output logic [CNT_W-1:0] match_cnt
);

  localparam int SW = (PAT_W > 2) ? $clog2(PAT_W) : 1;

  // Bit k of the pattern in arrival order (k = 0 is received first).
  function automatic logic pat_bit(input int k);
    logic [PAT_W-1:0] t;
    t = PATTERN >> (PAT_W - 1 - k);
    return t[0];
  endfunction

  // Longest proper border of the pattern prefix of length len.
  function automatic int border(input int len);
    int   res;
    logic ok;
    res = 0;
    for (int k = 1; k < len; k++) begin
      ok = 1'b1;
      for (int i = 0; i < k; i++)
        if (pat_bit(i) != pat_bit(len - k + i)) ok = 1'b0;
      if (ok) res = k;
    end
    return res;
  endfunction

  // KMP transition from prefix length s on bit b; full matches map to the border.
  function automatic int delta(input int s, input logic b);
    int   st;
    int   res;
    logic done;
    st   = s;
    res  = 0;
    done = 1'b0;
    for (int n = 0; n <= PAT_W; n++) begin
      if (!done) begin
        if (pat_bit(st) == b) begin
          res  = st + 1;
          done = 1'b1;
        end else if (st == 0) begin
          res  = 0;
          done = 1'b1;
        end else begin
          st = border(st);
        end
      end
    end
    if (res == PAT_W) res = border(PAT_W);
    return res;
  endfunction

  localparam int             BORDER = border(PAT_W);
  localparam logic [SW-1:0]  LAST   = SW'(PAT_W - 1);

  logic [SW-1:0] nxt0 [PAT_W];
  logic [SW-1:0] nxt1 [PAT_W];

  for (genvar g = 0; g < PAT_W; g++) begin : g_tbl
    assign nxt0[g] = SW'(delta(g, 1'b0));
    assign nxt1[g] = SW'(delta(g, 1'b1));
  end

  logic [SW-1:0] s_q;
  logic [SW-1:0] s_d;
  logic          hit;

  assign hit = in_valid & (s_q == LAST) & (x == PATTERN[0]);
  assign z   = rst_n & hit;

  always_comb begin
    s_d = s_q;
    if (in_valid) begin
      if (hit) s_d = overlap ? SW'(BORDER) : '0;
      else     s_d = x ? nxt1[s_q] : nxt0[s_q];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) s_q <= '0;
    else        s_q <= s_d;
  end

`ifdef SEQ_DET_CNT_EN
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // clr wins over a same-cycle match; the count sticks at all-ones.
  always_comb begin
    cnt_d = cnt_q;
    if (clr)                                cnt_d = '0;
    else if (z && (cnt_q != {CNT_W{1'b1}})) cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign match_cnt = cnt_q;
`else
  logic unused_clr;
  assign unused_clr = clr;
  assign match_cnt  = '0;
`endif

endmodule
